// File: rtl/decrypter_core.sv
// decrypter_core: iterative 76->60-bit decryption engine.
// Undoes ROUNDS rounds of x = rotl60(x ^ rk[r], ROT), then recomputes the
// 16-bit fold tag of the recovered plaintext and flags a mismatch.
// The round keys are regenerated in the forward direction first (KEYFWD),
// then walked backwards one per decrypt round (DEC).
// Optional: define DEC_ERR_CNT_EN to add a saturating 16-bit error counter
// on port err_count.
module decrypter_core #(
  parameter int ROUNDS = 8,
  parameter int ROT    = 13
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [59:0] key,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [75:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [59:0] out_data,
  output logic        out_err,
  output logic        busy
`ifdef DEC_ERR_CNT_EN
  , output logic [15:0] err_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_KEYFWD, S_DEC, S_CHECK, S_DONE
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(ROUNDS - 1);

  state_t      state_q;
  logic [59:0] x_q, kreg_q;
  logic [15:0] tag_q;
  logic [7:0]  cnt_q;

  logic [59:0] k_fwd_d, k_dec_d, x_dec_d;
  logic [7:0]  cnt_m1;

  function automatic logic [59:0] rotl1(input logic [59:0] v);
    return {v[58:0], v[59]};
  endfunction

  function automatic logic [59:0] rotr1(input logic [59:0] v);
    return {v[0], v[59:1]};
  endfunction

  function automatic logic [59:0] rotr_rot(input logic [59:0] v);
    return (v >> ROT) | (v << (60 - ROT));
  endfunction

  function automatic logic [15:0] fold16(input logic [59:0] v);
    logic [63:0] w;
    w = {4'b0, v};
    return w[63:48] ^ w[47:32] ^ w[31:16] ^ w[15:0];
  endfunction

  // Round datapath: forward key step, backward key step, inverse round.
  always_comb begin
    cnt_m1  = cnt_q - 8'd1;
    k_fwd_d = rotl1(kreg_q) ^ {52'b0, cnt_q};
    k_dec_d = rotr1(kreg_q ^ {52'b0, cnt_m1});
    x_dec_d = rotr_rot(x_q) ^ kreg_q;
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      kreg_q    <= '0;
      tag_q     <= '0;
      cnt_q     <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            x_q      <= in_data[59:0];
            tag_q    <= in_data[75:60];
            kreg_q   <= key;
            cnt_q    <= 8'd0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state_q  <= S_KEYFWD;
          end
        end
        // Walk the schedule up to rk[ROUNDS-1]; the exit edge does no step.
        S_KEYFWD: begin
          if (cnt_q == LAST_IDX) begin
            state_q <= S_DEC;
          end else begin
            kreg_q <= k_fwd_d;
            cnt_q  <= cnt_q + 8'd1;
          end
        end
        // One inverse round per cycle; the round using rk[0] is the last.
        S_DEC: begin
          x_q    <= x_dec_d;
          kreg_q <= k_dec_d;
          cnt_q  <= cnt_m1;
          if (cnt_q == 8'd0) state_q <= S_CHECK;
        end
        S_CHECK: begin
          out_data  <= x_q;
          out_err   <= (fold16(x_q) != tag_q);
          out_valid <= 1'b1;
          state_q   <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

`ifdef DEC_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  // Count handed-off words that carried a tag mismatch; saturates.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      err_cnt_q <= '0;
    end else if (state_q == S_DONE && out_ready && out_err &&
                 err_cnt_q != 16'hFFFF) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule
